// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 unsigned sequential multiplier built on one shared 4x4 multiplier
// Four nibble partial products are accumulated over four cycles, with valid/ready on both sides.

module i4bit_mul (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    output logic [7:0] p_o
);
    assign p_o = {4'b0000, x_i} * {4'b0000, y_i};
endmodule

module mul8_seq_ctrl #(
    parameter int unsigned ZERO_SKIP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state_q;
    logic [1:0]  step_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc_q;
    logic [15:0] acc_d;
    logic [15:0] p_q;
    logic        out_valid_q;
    logic        in_ready_q;
    logic        busy_q;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  pp;
    logic [15:0] pp_ext;
    logic        skip;

    // step[0] picks the high nibble of a, step[1] the high nibble of b
    assign nib_a  = step_q[0] ? a_q[7:4] : a_q[3:0];
    assign nib_b  = step_q[1] ? b_q[7:4] : b_q[3:0];
    assign pp_ext = {8'h00, pp};
    assign skip   = (ZERO_SKIP != 0) && ((a == 8'h00) || (b == 8'h00));

    i4bit_mul u_mul (
        .x_i (nib_a),
        .y_i (nib_b),
        .p_o (pp)
    );

    always_comb begin
        acc_d = acc_q;
        case (step_q)
            2'd0:    acc_d = acc_q + pp_ext;
            2'd3:    acc_d = acc_q + (pp_ext << 8);
            default: acc_d = acc_q + (pp_ext << 4);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            acc_q       <= 16'h0000;
            p_q         <= 16'h0000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc_q      <= 16'h0000;
                        step_q     <= 2'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (skip) begin
                            state_q     <= DONE;
                            p_q         <= 16'h0000;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_q     <= DONE;
                        p_q         <= acc_d;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // p_q is left untouched so the last product stays readable in IDLE
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb/tb_mul8_seq_ctrl.sv - self-checking bench for mul8_seq_ctrl, both ZERO_SKIP settings side by side
// Directed vector table, reset corner cases, then randomized traffic against a transaction-level model.

module tb_mul8_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_ready;
    logic [1:0]  ir;
    logic [1:0]  ov;
    logic [1:0]  bz;
    logic [15:0] pp [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul8_seq_ctrl #(.ZERO_SKIP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready),
        .p(pp[0]), .busy(bz[0])
    );

    mul8_seq_ctrl #(.ZERO_SKIP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready),
        .p(pp[1]), .busy(bz[1])
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_p);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_in_ready%0d", tag, d), 32'(ir[d]), 32'd1);
            chk($sformatf("%s_out_valid%0d", tag, d), 32'(ov[d]), 32'd0);
            chk($sformatf("%s_busy%0d", tag, d), 32'(bz[d]), 32'd0);
            chk($sformatf("%s_p%0d", tag, d), 32'(pp[d]), 32'(exp_p));
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One operation on both DUTs; garbage in_valid pulses while busy must be ignored.
    task automatic run_op(input vec_t v);
        int seen [2];
        int exp_lat;
        seen[0] = -1;
        seen[1] = -1;
        in_valid = 1'b1;
        a = v.a;
        b = v.b;
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            for (int d = 0; d < 2; d++)
                if (ov[d] && seen[d] < 0) seen[d] = k;
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_lat = (d == 1 && (v.a == 8'h00 || v.b == 8'h00)) ? 0 : 4;
            chk($sformatf("lat%0d_%h_%h", d, v.a, v.b), 32'(seen[d]), 32'(exp_lat));
            chk($sformatf("p%0d_%h_%h", d, v.a, v.b), 32'(pp[d]), 32'(v.p));
            chk($sformatf("busy%0d_%h_%h", d, v.a, v.b), 32'(bz[d]), 32'd1);
            chk($sformatf("ir_done%0d_%h_%h", d, v.a, v.b), 32'(ir[d]), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_idle($sformatf("post_hs_%h_%h", v.a, v.b), v.p);
    endtask

    // Transaction-level model state for the random phase
    logic        outst [2];
    int          age   [2];
    int          lat   [2];
    logic [15:0] prod  [2];
    logic [15:0] last  [2];
    int          served [2];

    initial begin
        logic        exp_ov;
        logic [15:0] exp_p;
        logic        never_valid;

        vecs[0] = '{8'h12, 8'h34, 16'h03A8};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'h00, 16'h0000};
        vecs[3] = '{8'h00, 8'hAB, 16'h0000};
        vecs[4] = '{8'h01, 8'h01, 16'h0001};
        vecs[5] = '{8'h0F, 8'h10, 16'h00F0};
        vecs[6] = '{8'hAB, 8'h00, 16'h0000};
        vecs[7] = '{8'h80, 8'h02, 16'h0100};

        a = 8'h00;
        b = 8'h00;
        do_reset();
        check_idle("reset", 16'h0000);

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Reset during MUL step 2 discards the pending product
        in_valid = 1'b1;
        a = 8'h80;
        b = 8'h80;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check_idle("rst_mul", 16'h0000);
        never_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (ov != 2'b00) never_valid = 1'b0;
            tick();
        end
        out_ready = 1'b0;
        chk("rst_mul_no_output", 32'(never_valid), 32'd1);
        run_op('{8'h03, 8'h05, 16'h000F});

        // Reset while holding a product in DONE
        in_valid = 1'b1;
        a = 8'h12;
        b = 8'h34;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("pre_rst_done_ov0", 32'(ov[0]), 32'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        check_idle("rst_done", 16'h0000);

        // Random traffic against the model
        do_reset();
        for (int d = 0; d < 2; d++) begin
            outst[d] = 1'b0;
            age[d] = 0;
            lat[d] = 4;
            prod[d] = 16'h0000;
            last[d] = 16'h0000;
            served[d] = 0;
        end
        for (int cyc = 0; cyc < 30000; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                exp_ov = outst[d] && (age[d] >= lat[d]);
                exp_p = exp_ov ? prod[d] : last[d];
                chk($sformatf("rand%0d_c%0d", d, cyc), 32'({ir[d], ov[d], pp[d]}),
                    32'({~outst[d], exp_ov, exp_p}));
            end
            in_valid = ($urandom_range(3) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(7) == 0) a = 8'h00;
            if ($urandom_range(7) == 0) b = 8'h00;
            out_ready = ($urandom_range(3) != 0);
            for (int d = 0; d < 2; d++) begin
                if (outst[d]) begin
                    if (age[d] >= lat[d] && out_ready) begin
                        outst[d] = 1'b0;
                        last[d] = prod[d];
                        served[d]++;
                    end else begin
                        age[d]++;
                    end
                end else if (in_valid) begin
                    outst[d] = 1'b1;
                    age[d] = 0;
                    prod[d] = 16'(a) * 16'(b);
                    lat[d] = (d == 1 && (a == 8'h00 || b == 8'h00)) ? 0 : 4;
                end
            end
            tick();
        end
        chk("rand_progress0", 32'(served[0] > 1000), 32'd1);
        chk("rand_progress1", 32'(served[1] > served[0]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul8_seq_ctrl.md
MUL8_SEQ_CTRL -- requirements
Module: mul8_seq_ctrl

Interface
REQ-001 SHALL have parameter ZERO_SKIP, default 0: when 1, operations with a zero operand bypass the multiply sequence.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port a, input, 8, unsigned multiplicand.
REQ-007 SHALL have port b, input, 8, unsigned multiplier.
REQ-008 SHALL have port out_valid, output, 1, product available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts product.
REQ-010 SHALL have port p, output, 16, unsigned product a*b.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL contain exactly one i4bit_mul instance and time-share it across all partial products; no other multiplier logic.
REQ-013 SHALL implement states IDLE, MUL, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; in_valid in MUL or DONE ignored, operands not sampled.
REQ-015 Accept = in_valid && in_ready at a rising edge: latch a, b into internal registers, clear accumulator, step counter := 0, go to MUL.
REQ-016 MUL SHALL run 4 cycles, 2-bit step counter 0..3, one partial product per cycle accumulated at the edge.
REQ-017 Steps: 0 a[3:0]*b[3:0] <<0; 1 a[7:4]*b[3:0] <<4; 2 a[3:0]*b[7:4] <<4; 3 a[7:4]*b[7:4] <<8.
REQ-018 Accumulator SHALL be 16 bits; partial products zero-extended before shift; no overflow possible (max 0xFE01).
REQ-019 At step-3 edge: state := DONE, p := final sum; latency 4 cycles from the accept edge to out_valid=1.
REQ-020 DONE: out_valid=1, p held stable until out_valid && out_ready at an edge, then state := IDLE, out_valid := 0.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 A new accept SHALL NOT occur in the same cycle as an output handshake (in_ready=0 in DONE); earliest next accept is the cycle after.
REQ-023 ZERO_SKIP=1 and (a==0 or b==0) at accept: go directly IDLE->DONE with p=0; out_valid visible 1 cycle after the accept edge.
REQ-024 ZERO_SKIP=0: zero operands SHALL take the full 4-cycle sequence.
REQ-025 p SHALL read 0 in IDLE and MUL until the first completion; after a handshake p SHALL hold the last product until the next completion.
REQ-026 Latched operands SHALL be independent of a/b after the accept edge; input changes during MUL do not affect the result.

Reset
REQ-027 rst=1 at an edge: state := IDLE, step counter := 0, accumulator := 0, p := 0, out_valid := 0, busy := 0, in_ready := 1 in the following cycle.
REQ-028 rst SHALL take priority over accept, accumulation, and output handshake in the same cycle.
REQ-029 Reset mid-MUL or in DONE SHALL abort the operation; the pending product is discarded, never presented.
REQ-030 The first accept SHALL be possible in the cycle after rst deasserts.

Verification
REQ-031 a=0x12, b=0x34, in_valid pulse, out_ready=1 -> out_valid exactly 4 cycles after accept, p=0x03A8, in_ready returns 1 the cycle after the handshake.
REQ-032 a=0xFF, b=0xFF -> p=0xFE01; a=0x00, b=0x00 with ZERO_SKIP=0 -> p=0x0000 after 4 cycles.
REQ-033 ZERO_SKIP=1, a=0x00, b=0xAB -> out_valid 1 cycle after accept, p=0x0000; a=0x01, b=0x01 -> normal 4-cycle path, p=0x0001.
REQ-034 Backpressure: out_ready=0 for 5 cycles after a=0x0F, b=0x10 -> out_valid and p=0x00F0 held stable; in_valid with a=0x02, b=0x02 during this window ignored; handshake then returns the block to IDLE.
REQ-035 rst pulse during MUL step 2 of a=0x80, b=0x80 -> next cycle IDLE, out_valid=0, p=0; next op a=0x03, b=0x05 yields p=0x000F.
REQ-036 Random self-check: 10k random a, b with random in_valid/out_ready, compared against the a*b reference model; every product accepted exactly once, in order.
